// File: rtl/sigmoid_arb_pkg.sv
// Shared definitions for the sigmoid round-robin scheduler: FSM encoding,
// IEEE-754 constants and the requester index width helper.
package sigmoid_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sigmoid_arb_rr_pick.sv
// Combinational round-robin picker: starting at ptr and wrapping, grants
// the first set bit of elig. Produces a one-hot grant and its index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan N candidates in rotated order; the first eligible one wins.
  always_comb begin
    int c;
    logic [IW-1:0] ci;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    ci    = '0;
    for (int k = 0; k < N; k++) begin
      c  = (int'(ptr) + k) % N;
      ci = IW'(c);
      if (!any && elig[ci]) begin
        any       = 1'b1;
        grant[ci] = 1'b1;
        idx       = ci;
      end
    end
  end

endmodule

// File: rtl/sigmoid_arb.sv
// Shares one sigmoid core among NREQ requesters. One op in flight at a time:
// IDLE picks a requester, CLR resets the core, START pulses it, WAIT collects
// the result (or a quiet NaN on timeout) into that requester's response slot.
module sigmoid_arb
  import sigmoid_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              res,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_num,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [NREQ*W-1:0] rsp_sig,
  output logic [NREQ-1:0]   rsp_err,
  output logic              act_clr,
  output logic              act_start,
  output logic [W-1:0]      act_num,
  input  logic              act_done,
  input  logic [W-1:0]      act_sig,
  output logic              busy
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e          state_reg, state_next;
  logic [IW-1:0]   rr_reg, idx_reg;
  logic [W-1:0]    act_num_reg;
  logic [CW-1:0]   cnt_reg;
  logic [NREQ-1:0] rsp_valid_reg, rsp_err_reg;
  logic [W-1:0]    rsp_sig_reg [NREQ];
  logic [W-1:0]    req_num_arr [NREQ];

  logic [NREQ-1:0] elig, grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            accept, done_hit, tmo_hit, finish;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .elig  (elig),
    .ptr   (rr_reg),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign accept   = (state_reg == ST_IDLE) && pick_any;
  assign done_hit = (state_reg == ST_WAIT) && act_done;
  assign tmo_hit  = (state_reg == ST_WAIT) && !act_done && (cnt_reg == CW'(TIMEOUT));
  assign finish   = done_hit || tmo_hit;

  // Next-state logic: fixed CLR/START sequence, WAIT ends on done or timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_CLR;
      ST_CLR:   state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (finish) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Control registers: state, pointer, latched operand/index, wait counter.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_reg   <= ST_IDLE;
      rr_reg      <= '0;
      idx_reg     <= '0;
      act_num_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        idx_reg     <= pick_idx;
        act_num_reg <= req_num_arr[pick_idx];
        rr_reg      <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (state_reg == ST_START) cnt_reg <= '0;
      else if (state_reg == ST_WAIT) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_num_arr[gi]       = req_num[gi*W +: W];
      // A slot holding an unconsumed result is not offered a new op.
      assign elig[gi]              = req_valid[gi] && !rsp_valid_reg[gi];
      assign req_ready[gi]         = (state_reg == ST_IDLE) && grant[gi];
      assign rsp_sig[gi*W +: W]    = rsp_sig_reg[gi];

      // Per-requester response slot: filled at op end, emptied on handshake.
      always_ff @(posedge clk) begin
        if (!res) begin
          rsp_valid_reg[gi] <= 1'b0;
          rsp_err_reg[gi]   <= 1'b0;
          rsp_sig_reg[gi]   <= '0;
        end else if (finish && (idx_reg == IW'(gi))) begin
          rsp_valid_reg[gi] <= 1'b1;
          rsp_err_reg[gi]   <= tmo_hit;
          rsp_sig_reg[gi]   <= done_hit ? act_sig : W'(FP_QNAN);
        end else if (rsp_valid_reg[gi] && rsp_ready[gi]) begin
          rsp_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // The core is held in reset whenever this block is, and pulsed in CLR.
  assign act_clr   = res && (state_reg != ST_CLR);
  assign act_start = (state_reg == ST_START);
  assign act_num   = act_num_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_sigmoid_arb.sv
// Bench for sigmoid_arb: a behavioural core model, a cycle-level reference of
// the scheduling rules, and a scoreboard monitor checking every result.
module tb_sigmoid_arb;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TMO = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] SIGX = 32'h3F00_0000;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   rsp_ready = '0;
  logic [N*W-1:0] req_num   = '0;
  logic           act_done  = 1'b0;
  logic [W-1:0]   act_sig   = '0;
  logic [N-1:0]   req_ready, rsp_valid, rsp_err;
  logic [N*W-1:0] rsp_sig;
  logic           act_clr, act_start, busy;
  logic [W-1:0]   act_num;

  always #5 clk = ~clk;

  sigmoid_arb #(.NREQ(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .res(res),
    .req_valid(req_valid), .req_ready(req_ready), .req_num(req_num),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sig(rsp_sig), .rsp_err(rsp_err),
    .act_clr(act_clr), .act_start(act_start), .act_num(act_num),
    .act_done(act_done), .act_sig(act_sig), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          idx;
    logic [31:0] sig;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  // Reference state
  bit          m_known = 0, m_rst = 0, m_busy = 0;
  int          m_age = 0, m_idx = 0, m_rr = 0;
  logic [N-1:0] m_pend = '0;
  logic [31:0] m_num = '0;
  // Core model state; latency <0 means the core never answers
  int core_lat = 10, op_lat = 10, cd = -1, inject = 0;
  logic [N-1:0] prev_valid = '0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v, input logic [N-1:0] pend, input int rr);
    for (int k = 0; k < N; k++) begin
      int j = (rr + k) % N;
      if (v[j] && !pend[j]) return j;
    end
    return -1;
  endfunction

  // Core model, per-cycle reference checks and reference update
  always @(negedge clk) begin
    int g;
    int wc;
    bit dn;
    bit e;
    logic [N-1:0] exp_ready;
    dn = 0;
    if (!act_clr) cd = -1;
    else if (act_start) begin
      cd = -1;
      if (op_lat == 0) dn = 1;
      else if (op_lat > 0) cd = op_lat;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) dn = 1;
    end
    if (inject > 0) begin
      dn = 1;
      inject--;
    end
    act_done = dn;
    act_sig  = dn ? (act_num ^ SIGX) : W'($urandom);

    g = m_busy ? -1 : model_pick(req_valid, m_pend, m_rr);
    if (m_known) begin
      exp_ready = (g >= 0) ? (N'(1) << g) : '0;
      chk("busy", 128'(busy), 128'(m_busy));
      chk("act_clr", 128'(act_clr), 128'(res && !(m_busy && m_age == 1)));
      chk("act_start", 128'(act_start), 128'(m_busy && m_age == 2));
      chk("req_ready", 128'(req_ready), 128'(exp_ready));
      chk("rsp_valid", 128'(rsp_valid), 128'(m_pend));
      if (m_busy) chk("act_num", 128'(act_num), 128'(m_num));
      if (m_rst) begin
        chk("rst_rsp_err", 128'(rsp_err), 128'(0));
        chk("rst_rsp_sig", 128'(rsp_sig), 128'(0));
        chk("rst_act_num", 128'(act_num), 128'(0));
      end
    end

    if (!res) begin
      if (m_busy && sb_q.size() > 0) void'(sb_q.pop_back());
      m_known = 1; m_rst = 1; m_busy = 0; m_age = 0; m_rr = 0; m_pend = '0;
    end else if (m_known) begin
      m_rst = 0;
      for (int i = 0; i < N; i++)
        if (m_pend[i] && rsp_ready[i]) m_pend[i] = 1'b0;
      if (m_busy) begin
        if (m_age >= 3) begin
          wc = m_age - 3;
          if (act_done || wc == TMO) begin
            m_pend[m_idx] = 1'b1;
            m_busy = 0;
          end
        end
        if (m_busy) m_age++;
      end else if (g >= 0) begin
        m_busy = 1; m_age = 1; m_idx = g; m_rr = (g + 1) % N;
        m_num  = req_num[g*W +: W];
        op_lat = core_lat;
        e = !(op_lat >= 1 && op_lat <= TMO + 1);
        sb_q.push_back('{idx: g, sig: e ? QNAN : (m_num ^ SIGX), err: e});
      end
    end
  end

  // Scoreboard monitor: each newly presented result is matched in order
  always @(negedge clk) begin
    exp_t x;
    for (int i = 0; i < N; i++) begin
      if (m_known && rsp_valid[i] && !prev_valid[i]) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rsp_unexpected: slot %0d got %0h, no result expected", i, rsp_sig[i*W +: W]);
        end else begin
          x = sb_q.pop_front();
          chk("rsp_slot", 128'(i), 128'(x.idx));
          chk("rsp_sig", 128'(rsp_sig[i*W +: W]), 128'(x.sig));
          chk("rsp_err", 128'(rsp_err[i]), 128'(x.err));
        end
      end
    end
    prev_valid = rsp_valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int i, input int max);
    bit hit = 0;
    for (int k = 0; k < max && !hit; k++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) hit = 1;
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL accept_timeout: requester %0d got no grant, required within %0d cycles", i, max);
    end
    cyc(1);
  endtask

  task automatic wait_rsp(input int i, input int max);
    bit hit = 0;
    for (int k = 0; k < max && !hit; k++) begin
      @(negedge clk);
      if (rsp_valid[i]) hit = 1;
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rsp_timeout: requester %0d got no result, required within %0d cycles", i, max);
    end
    cyc(1);
  endtask

  task automatic wait_quiet(input int max);
    bit hit = 0;
    for (int k = 0; k < max && !hit; k++) begin
      @(negedge clk);
      if (!busy && rsp_valid == '0) hit = 1;
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL quiet_timeout: busy=%0d rsp_valid=%0h, required idle within %0d cycles", busy, rsp_valid, max);
    end
    cyc(1);
  endtask

  task automatic rand_nums();
    for (int i = 0; i < N; i++) req_num[i*W +: W] = $urandom;
  endtask

  initial begin
    int lats[5];
    lats = '{-1, 0, TMO + 1, TMO + 2, 5};

    // Reset for two cycles
    res = 1'b0;
    repeat (2) @(posedge clk);
    #1 res = 1'b1;
    cyc(2);

    // Single request from requester 2, operand 0, core latency 10
    core_lat = 10;
    req_num = '0;
    req_valid = 4'b0100;
    wait_accept(2, 20);
    req_valid = '0;
    wait_rsp(2, 40);
    rsp_ready = 4'b0100;
    cyc(1);
    rsp_ready = '0;
    wait_quiet(20);

    // Round robin with everyone valid and draining
    rsp_ready = '1;
    req_valid = '1;
    for (int k = 0; k < 60; k++) begin
      rand_nums();
      core_lat = $urandom_range(1, 12);
      cyc(1);
    end

    // Randomised traffic
    for (int k = 0; k < 800; k++) begin
      rand_nums();
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      core_lat  = $urandom_range(1, 15);
      cyc(1);
    end
    req_valid = '0;
    rsp_ready = '1;
    wait_quiet(100);

    // Back-pressure: requester 1 never drains, 3 keeps being served
    rsp_ready = 4'b1101;
    req_valid = 4'b1010;
    core_lat  = 4;
    for (int k = 0; k < 80; k++) begin
      rand_nums();
      cyc(1);
    end
    rsp_ready = '1;
    for (int k = 0; k < 30; k++) begin
      rand_nums();
      cyc(1);
    end
    req_valid = '0;
    wait_quiet(100);

    // Timeout and done-latency boundaries on requester 0
    rsp_ready = '0;
    for (int t = 0; t < 5; t++) begin
      core_lat = lats[t];
      req_num[0 +: W] = $urandom;
      req_valid = 4'b0001;
      wait_accept(0, 20);
      req_valid = '0;
      wait_rsp(0, TMO + 20);
      rsp_ready = 4'b0001;
      cyc(1);
      rsp_ready = '0;
      wait_quiet(20);
    end

    // Reset in WAIT, then a stray done from the core
    core_lat = 60;
    req_valid = 4'b0010;
    wait_accept(1, 20);
    req_valid = '0;
    cyc(10);
    res = 1'b0;
    cyc(2);
    res = 1'b1;
    inject = 3;
    cyc(10);
    rsp_ready = '1;
    req_valid = '1;
    core_lat = 3;
    for (int k = 0; k < 30; k++) begin
      rand_nums();
      cyc(1);
    end
    req_valid = '0;
    wait_quiet(100);

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d results outstanding, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sigmoid_arb.md
# sigmoid_arb

Round-robin scheduler that shares one sigmoid evaluation core among `NREQ` requesters. Each requester presents one IEEE-754 single-precision operand through a valid/ready handshake. The block clears, starts and waits on the core, then returns the result to a per-requester response buffer with its own valid/ready handshake. It sits between the neuron-layer sequencers and the single `sigmoid` instance, and owns the core's reset and start strobes.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `W`, 32: operand/result width (IEEE-754 single).
- `TIMEOUT`, 255: maximum cycles in WAIT before the op is aborted.
- `clk`  in  1  single clock; all logic on the rising edge.
- `res`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NREQ  requester i has an operand.
- `req_ready`  out  NREQ  one-hot grant; the operand is accepted when `req_valid[i] & req_ready[i]`.
- `req_num`  in  NREQ*W  operands; slice i is `[i*W +: W]`.
- `rsp_valid`  out  NREQ  result pending for requester i.
- `rsp_ready`  in  NREQ  requester i consumes its result.
- `rsp_sig`  out  NREQ*W  per-requester result registers.
- `rsp_err`  out  NREQ  the result came from a timeout.
- `act_clr`  out  1  core reset strobe, active-low (drives the core's `res`).
- `act_start`  out  1  one-cycle start pulse to the core.
- `act_num`  out  W  operand to the core, held stable from CLR until the op ends.
- `act_done`  in  1  core result valid; sampled only in WAIT.
- `act_sig`  in  W  core result.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, CLR, START, WAIT.
- **Eligibility.** Requester i is eligible when `req_valid[i] & !rsp_valid[i]`. A requester whose result is still unconsumed is never re-granted, so a result is never overwritten.
- **IDLE.** Search for the first eligible requester starting at pointer `rr`, wrapping modulo NREQ.
  - `req_ready` is combinational and one-hot to that requester.
  - On transfer: latch the index and `req_num` slice into `act_num`, set `rr` to index+1 (wrapping), go to CLR.
  - If nobody is eligible, `req_ready` is 0.
- **CLR.** `act_clr` = 0 for one cycle, then go to START.
- **START.** `act_start` = 1 for one cycle, clear the timeout counter, go to WAIT.
- **WAIT.**
  - If `act_done`: write `act_sig` into `rsp_sig[idx]`, set `rsp_valid[idx]`, clear `rsp_err[idx]`, go to IDLE.
  - Else the counter increments. If the counter equals TIMEOUT: write 0x7FC00000 (quiet NaN), set `rsp_valid[idx]` and `rsp_err[idx]`, go to IDLE.
- **Response drain.** `rsp_valid[i]` clears on `rsp_valid[i] & rsp_ready[i]`, independently per requester and in any state. A drain and a new result write for the same i in the same cycle cannot occur, because a requester with a pending result is not eligible.
- **Drain re-grant.** A requester draining in IDLE becomes eligible in the next cycle, not the same cycle.
- **Reset** (`res` = 0 at a clock edge), including mid-operation:
  - State goes to IDLE, `rr` = 0.
  - All `rsp_valid`/`rsp_err` = 0, `rsp_sig` = 0, `act_num` = 0.
  - `act_clr` = 0 (the core is held in reset while the block is in reset).
  - `act_start` = 0, `busy` = 0.
  - An in-flight result is discarded.
- Outside reset and CLR, `act_clr` = 1.

## Timing
- Accept at cycle T (IDLE) gives CLR at T+1 and START at T+2. WAIT begins at T+3.
- `act_done` at cycle D ≥ T+3 gives `rsp_valid` high at D+1, with the block back in IDLE at D+1. A new accept is possible at D+1.
- With the core's done in the same cycle as its start, done is ignored; only WAIT samples it.
- A timeout with no done gives `rsp_err` at T+3+TIMEOUT+1.
- Issue overhead is 3 cycles per op plus core latency. There is no pipelining across ops; one op is in flight at a time.
- `req_ready` is 0 in every state except IDLE.

## Structure
- Shared package holds:
  - FSM state encoding (2-bit enum).
  - `FP_ONE` = 0x3F800000.
  - `FP_QNAN` = 0x7FC00000.
  - Clog2 index width for NREQ.
- Sub-module `rr_pick`: combinational round-robin priority picker (eligible vector plus pointer to one-hot grant plus index). Unit-testable on its own.

## Test plan
- **Reset.** Reset for 2 cycles. Then all outputs are 0, `act_clr` = 0 during reset and 1 afterwards.
- **Single request.** Requester 2 requests 0x00000000 and the core model returns 0x3F000000 after 10 cycles. Then `act_clr` low at T+1, `act_start` at T+2, `rsp_valid[2]` with `rsp_sig` slice 2 = 0x3F000000 at D+1, and `rsp_err[2]` = 0.
- **Round robin.** All 4 requesters are valid continuously with `rsp_ready` tied 1. Grants go 0, 1, 2, 3, 0, with each result tagged to the correct slice.
- **Back-pressure.** Requester 1 holds `rsp_ready` = 0 while requesters 1 and 3 are both valid. After its first result, 1 is never re-granted and 3 is served. Releasing `rsp_ready[1]` re-admits 1 the following cycle.
- **Timeout.** The core never asserts done with TIMEOUT = 255. Then `rsp_err[0]` = 1 with the slice = 0x7FC00000, and the next request proceeds normally.
- **Reset mid-operation.** Assert reset in WAIT, then release. Then IDLE with no `rsp_valid`, and the late `act_done` is ignored.
